// File: rtl/quiz_round_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// quiz_pkg
// Shared types and constants for the 4-player quiz responder round controller.
//   state_t     : round sequencer states (IDLE, ARMED, ANSWER)
//   N_PLAYERS   : number of player keys
//   SCORE_W     : width of one player's score field
//   BCD_W       : width of one BCD digit
//   sec_to_bcd  : converts a 0..99 seconds value into two packed BCD digits
// -----------------------------------------------------------------------------
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ANSWER
  } state_t;

  localparam int N_PLAYERS = 4;
  localparam int SCORE_W   = 4;
  localparam int BCD_W     = 4;

  // Tens digit in the upper nibble, units digit in the lower nibble.
  function automatic logic [2*BCD_W-1:0] sec_to_bcd(input int unsigned sec);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
    tens  = BCD_W'(sec / 10);
    units = BCD_W'(sec % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/quiz_round_ctrl_bcd_countdown.sv
// -----------------------------------------------------------------------------
// bcd_countdown
// Tick divider plus a two-digit BCD seconds down-counter for the answer window.
//   CLK, RSTn : clock and asynchronous active-low reset
//   load      : load ANSWER_SEC into the digits and restart the divider
//   run       : the round stays in its answer phase this cycle; count down
//   TimerH/L  : remaining seconds, BCD tens / units (registered)
//   expire    : high in the cycle whose clock edge takes the counter to 00
// When neither load nor run is high the counter is held at 00, so the timer
// reads zero in the same cycle the round leaves its answer phase.
// -----------------------------------------------------------------------------
module bcd_countdown
  import quiz_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned ANSWER_SEC = 20
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             load,
  input  logic             run,
  output logic [BCD_W-1:0] TimerH,
  output logic [BCD_W-1:0] TimerL,
  output logic             expire
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [2*BCD_W-1:0] LOAD_BCD = sec_to_bcd(ANSWER_SEC);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  // The expiry strobe is combinational so the top can register the TimeOver
  // pulse on the same edge that the digits fall to 00.
  always_comb begin
    tick   = (div_cnt == DIV_LAST);
    expire = run && tick && (TimerH == '0) && (TimerL == BCD_W'(1));
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      div_cnt <= '0;
      TimerH  <= '0;
      TimerL  <= '0;
    end else if (load) begin
      div_cnt <= '0;
      TimerH  <= LOAD_BCD[2*BCD_W-1:BCD_W];
      TimerL  <= LOAD_BCD[BCD_W-1:0];
    end else if (run) begin
      if (tick) begin
        div_cnt <= '0;
        if (TimerL == '0) begin
          TimerL <= BCD_W'(9);
          TimerH <= TimerH - BCD_W'(1);
        end else begin
          TimerL <= TimerL - BCD_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end else begin
      div_cnt <= '0;
      TimerH  <= '0;
      TimerL  <= '0;
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// -----------------------------------------------------------------------------
// quiz_round_ctrl
// Round sequencer and first-press arbiter for the 4-player quiz responder.
//   CLK, RSTn       : clock and asynchronous active-low reset
//   Start           : host round switch (rise arms a round, low aborts it)
//   Key_In[3:0]     : player keys, bit 0 = player 1
//   Judge_OK/NG     : one-cycle verdict pulses for the granted answer
//   LED_Out[3:0]    : one-hot granted player
//   Player_Number   : granted player 1..4, 0 when none
//   TimerH/TimerL   : remaining answer seconds in BCD
//   Score_Bus[15:0] : four saturating 4-bit scores, [3:0] = player 1
//   Foul_Out[3:0]   : players disqualified for the current/pending round
//   Buzzer_Answer   : one-cycle pulse on grant
//   Buzzer_TimeOver : one-cycle pulse on countdown expiry
// -----------------------------------------------------------------------------
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned ANSWER_SEC = 20,
  parameter int unsigned SCORE_MAX  = 9
) (
  input  logic                           CLK,
  input  logic                           RSTn,
  input  logic                           Start,
  input  logic [N_PLAYERS-1:0]           Key_In,
  input  logic                           Judge_OK,
  input  logic                           Judge_NG,
  output logic [N_PLAYERS-1:0]           LED_Out,
  output logic [3:0]                     Player_Number,
  output logic [BCD_W-1:0]               TimerH,
  output logic [BCD_W-1:0]               TimerL,
  output logic [N_PLAYERS*SCORE_W-1:0]   Score_Bus,
  output logic [N_PLAYERS-1:0]           Foul_Out,
  output logic                           Buzzer_Answer,
  output logic                           Buzzer_TimeOver
);

  localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

  state_t               state;
  logic [N_PLAYERS-1:0] key_q;
  logic [N_PLAYERS-1:0] key_evt;
  logic                 start_q;
  logic                 start_evt;
  logic [1:0]           grant_idx;
  logic [SCORE_W-1:0]   score [N_PLAYERS];

  logic [N_PLAYERS-1:0] valid_evt;
  logic [1:0]           grant_sel;
  logic                 grant;
  logic                 stay_answer;
  logic                 expire;

  // Key and Start edges are registered before the FSM sees them, so a press
  // sampled at one edge is acted on at the next. Start goes through the same
  // stage so a Start rise and a key press sampled together reach the IDLE
  // state together and the key is recorded as a foul before arming.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_q     <= '0;
      key_evt   <= '0;
      start_q   <= 1'b0;
      start_evt <= 1'b0;
    end else begin
      key_q     <= Key_In;
      key_evt   <= Key_In & ~key_q;
      start_q   <= Start;
      start_evt <= Start & ~start_q;
    end
  end

  // Fixed-priority arbitration among non-fouled presses; lowest index wins.
  // stay_answer tells the countdown whether the round survives this edge, so
  // judge pulses and aborts both suppress the expiry strobe and clear the
  // digits on the way back to IDLE.
  always_comb begin
    valid_evt = key_evt & ~Foul_Out;
    grant_sel = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (valid_evt[i]) grant_sel = 2'(i);
    end
    grant       = (state == ARMED) && Start && (valid_evt != '0);
    stay_answer = (state == ANSWER) && Start && !Judge_OK && !Judge_NG;
  end

  bcd_countdown #(
    .TICK_DIV   (TICK_DIV),
    .ANSWER_SEC (ANSWER_SEC)
  ) u_countdown (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .load   (grant),
    .run    (stay_answer),
    .TimerH (TimerH),
    .TimerL (TimerL),
    .expire (expire)
  );

  // Round sequencer. Every path back to IDLE from a round clears the grant
  // and the fouls; scores survive everything except reset. Abort has priority
  // over a verdict, and a verdict has priority over expiry.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state           <= IDLE;
      grant_idx       <= '0;
      LED_Out         <= '0;
      Player_Number   <= '0;
      Foul_Out        <= '0;
      Buzzer_Answer   <= 1'b0;
      Buzzer_TimeOver <= 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) score[i] <= '0;
    end else begin
      Buzzer_Answer   <= 1'b0;
      Buzzer_TimeOver <= 1'b0;
      case (state)
        IDLE: begin
          Foul_Out <= Foul_Out | key_evt;
          if (start_evt) state <= ARMED;
        end
        ARMED: begin
          if (!Start) begin
            state         <= IDLE;
            LED_Out       <= '0;
            Player_Number <= '0;
            Foul_Out      <= '0;
          end else if (grant) begin
            state         <= ANSWER;
            grant_idx     <= grant_sel;
            LED_Out       <= N_PLAYERS'(1) << grant_sel;
            Player_Number <= 4'(grant_sel) + 4'd1;
            Buzzer_Answer <= 1'b1;
          end
        end
        ANSWER: begin
          if (!Start || Judge_OK || Judge_NG || expire) begin
            state         <= IDLE;
            LED_Out       <= '0;
            Player_Number <= '0;
            Foul_Out      <= '0;
          end
          if (Start) begin
            if (Judge_OK) begin
              if (score[grant_idx] < SCORE_TOP)
                score[grant_idx] <= score[grant_idx] + SCORE_W'(1);
            end else if (Judge_NG) begin
              if (score[grant_idx] != '0)
                score[grant_idx] <= score[grant_idx] - SCORE_W'(1);
            end else if (expire) begin
              Buzzer_TimeOver <= 1'b1;
            end
          end
        end
        default: begin
          state         <= IDLE;
          LED_Out       <= '0;
          Player_Number <= '0;
          Foul_Out      <= '0;
        end
      endcase
    end
  end

  // Scores are kept as an array and flattened onto the bus, player 1 lowest.
  always_comb begin
    Score_Bus = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      Score_Bus[i*SCORE_W +: SCORE_W] = score[i];
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_quiz_round_ctrl
// Self-checking bench for quiz_round_ctrl with TICK_DIV=10, ANSWER_SEC=3.
// A behavioural model tracks the round as "cycles since grant" and derives
// the timer from that; a compare process checks every output each cycle, and
// directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_quiz_round_ctrl;

  localparam int TICK_DIV   = 10;
  localparam int ANSWER_SEC = 3;
  localparam int SCORE_MAX  = 9;

  logic        CLK;
  logic        RSTn;
  logic        Start;
  logic [3:0]  Key_In;
  logic        Judge_OK;
  logic        Judge_NG;
  logic [3:0]  LED_Out;
  logic [3:0]  Player_Number;
  logic [3:0]  TimerH;
  logic [3:0]  TimerL;
  logic [15:0] Score_Bus;
  logic [3:0]  Foul_Out;
  logic        Buzzer_Answer;
  logic        Buzzer_TimeOver;

  int pass_count = 0;
  int check_count = 0;

  quiz_round_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .ANSWER_SEC (ANSWER_SEC),
    .SCORE_MAX  (SCORE_MAX)
  ) dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .Start           (Start),
    .Key_In          (Key_In),
    .Judge_OK        (Judge_OK),
    .Judge_NG        (Judge_NG),
    .LED_Out         (LED_Out),
    .Player_Number   (Player_Number),
    .TimerH          (TimerH),
    .TimerL          (TimerL),
    .Score_Bus       (Score_Bus),
    .Foul_Out        (Foul_Out),
    .Buzzer_Answer   (Buzzer_Answer),
    .Buzzer_TimeOver (Buzzer_TimeOver)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: phase 0 = no round, 1 = waiting for a press,
  // 2 = answering. Presses and Start rises seen at one edge take effect at
  // the next edge.
  int       m_phase;
  int       m_elapsed;
  int       m_winner;
  int       m_score [4];
  bit [3:0] m_foul;
  bit       m_ba;
  bit       m_bt;
  bit [3:0] m_prev_keys;
  bit [3:0] m_key_pend;
  bit       m_prev_start;
  bit       m_start_pend;

  task automatic modelEndRound();
    m_phase  = 0;
    m_winner = 0;
    m_foul   = '0;
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_phase = 0; m_elapsed = 0; m_winner = 0; m_foul = '0;
      m_ba = 0; m_bt = 0;
      m_prev_keys = '0; m_key_pend = '0; m_prev_start = 0; m_start_pend = 0;
      for (int i = 0; i < 4; i++) m_score[i] = 0;
    end else begin
      bit [3:0] v;
      m_ba = 0;
      m_bt = 0;
      if (m_phase == 0) begin
        m_foul = m_foul | m_key_pend;
        if (m_start_pend) m_phase = 1;
      end else if (m_phase == 1) begin
        v = m_key_pend & ~m_foul;
        if (!Start) modelEndRound();
        else if (v != 0) begin
          for (int i = 3; i >= 0; i--) if (v[i]) m_winner = i + 1;
          m_elapsed = 0;
          m_ba = 1;
          m_phase = 2;
        end
      end else begin
        if (!Start) modelEndRound();
        else if (Judge_OK) begin
          if (m_score[m_winner-1] < SCORE_MAX) m_score[m_winner-1]++;
          modelEndRound();
        end else if (Judge_NG) begin
          if (m_score[m_winner-1] > 0) m_score[m_winner-1]--;
          modelEndRound();
        end else begin
          m_elapsed++;
          if (m_elapsed == ANSWER_SEC * TICK_DIV) begin
            m_bt = 1;
            modelEndRound();
          end
        end
      end
      m_key_pend   = Key_In & ~m_prev_keys;
      m_prev_keys  = Key_In;
      m_start_pend = Start & ~m_prev_start;
      m_prev_start = Start;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    check_count++;
    if (act !== exp)
      $display("[TB] FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    else
      pass_count++;
  endtask

  // Compare every output against the model shortly after each edge.
  always @(posedge CLK) begin
    int rem;
    logic [7:0]  exp_timer;
    logic [15:0] exp_sb;
    #1;
    rem = (m_phase == 2) ? ANSWER_SEC - m_elapsed / TICK_DIV : 0;
    exp_timer = {4'(rem / 10), 4'(rem % 10)};
    exp_sb = {4'(m_score[3]), 4'(m_score[2]), 4'(m_score[1]), 4'(m_score[0])};
    checkOutput("model_led", 32'(LED_Out),
                (m_winner != 0) ? 32'(1 << (m_winner - 1)) : 32'd0);
    checkOutput("model_player", 32'(Player_Number), 32'(m_winner));
    checkOutput("model_timer", 32'({TimerH, TimerL}), 32'(exp_timer));
    checkOutput("model_score", 32'(Score_Bus), 32'(exp_sb));
    checkOutput("model_foul", 32'(Foul_Out), 32'(m_foul));
    checkOutput("model_buz_ans", 32'(Buzzer_Answer), 32'(m_ba));
    checkOutput("model_buz_to", 32'(Buzzer_TimeOver), 32'(m_bt));
  end

  // Drive one cycle of inputs from a falling edge to the next falling edge.
  task automatic applyStimulus(input logic s, input logic [3:0] k,
                               input logic ok, input logic ng);
    Start    = s;
    Key_In   = k;
    Judge_OK = ok;
    Judge_NG = ng;
    @(negedge CLK);
  endtask

  // Arm a round from Start low and press the given keys; returns with the
  // grant visible.
  task automatic grantPlayer(input logic [3:0] k);
    applyStimulus(0, 4'b0000, 0, 0);
    applyStimulus(1, 4'b0000, 0, 0);
    applyStimulus(1, k, 0, 0);
    applyStimulus(1, k, 0, 0);
  endtask

  initial begin
    RSTn = 0; Start = 0; Key_In = 0; Judge_OK = 0; Judge_NG = 0;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("reset_led", 32'(LED_Out), 32'd0);
    checkOutput("reset_timer", 32'({TimerH, TimerL}), 32'd0);
    checkOutput("reset_score", 32'(Score_Bus), 32'd0);
    RSTn = 1;
    applyStimulus(0, 4'b0000, 0, 0);

    $display("[TB] scenario: player 3 grant and correct verdict");
    grantPlayer(4'b0100);
    checkOutput("s1_led", 32'(LED_Out), 32'h4);
    checkOutput("s1_player", 32'(Player_Number), 32'd3);
    checkOutput("s1_buz_ans", 32'(Buzzer_Answer), 32'd1);
    checkOutput("s1_timer", 32'({TimerH, TimerL}), 32'h03);
    applyStimulus(1, 4'b0100, 0, 0);
    checkOutput("s1_buz_ans_pulse", 32'(Buzzer_Answer), 32'd0);
    applyStimulus(1, 4'b0100, 1, 0);
    checkOutput("s1_score3", 32'(Score_Bus), 32'h0100);
    checkOutput("s1_led_clr", 32'(LED_Out), 32'd0);
    applyStimulus(1, 4'b0000, 0, 0);

    $display("[TB] scenario: simultaneous presses, wrong verdict at zero");
    grantPlayer(4'b0110);
    checkOutput("s2_player", 32'(Player_Number), 32'd2);
    applyStimulus(1, 4'b0111, 0, 0);
    applyStimulus(1, 4'b0111, 0, 0);
    checkOutput("s2_led_hold", 32'(LED_Out), 32'h2);
    applyStimulus(1, 4'b0111, 0, 1);
    checkOutput("s2_score_floor", 32'(Score_Bus), 32'h0100);
    applyStimulus(0, 4'b0000, 0, 0);

    $display("[TB] scenario: early press fouls player 1");
    applyStimulus(0, 4'b0001, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0);
    checkOutput("s3_foul_idle", 32'(Foul_Out), 32'h1);
    applyStimulus(1, 4'b0000, 0, 0);
    applyStimulus(1, 4'b0000, 0, 0);
    checkOutput("s3_foul_armed", 32'(Foul_Out), 32'h1);
    applyStimulus(1, 4'b0001, 0, 0);
    applyStimulus(1, 4'b0001, 0, 0);
    checkOutput("s3_fouled_ignored", 32'(LED_Out), 32'h0);
    applyStimulus(1, 4'b1001, 0, 0);
    applyStimulus(1, 4'b1001, 0, 0);
    checkOutput("s3_player4", 32'(Player_Number), 32'd4);
    checkOutput("s3_led4", 32'(LED_Out), 32'h8);

    $display("[TB] scenario: countdown expiry");
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(1, 4'b1001, 0, 0);
      if (i == 9)  checkOutput("s4_timer_9", 32'({TimerH, TimerL}), 32'h03);
      if (i == 10) checkOutput("s4_timer_10", 32'({TimerH, TimerL}), 32'h02);
      if (i == 20) checkOutput("s4_timer_20", 32'({TimerH, TimerL}), 32'h01);
      if (i == 29) checkOutput("s4_to_early", 32'(Buzzer_TimeOver), 32'd0);
      if (i == 30) begin
        checkOutput("s4_timer_00", 32'({TimerH, TimerL}), 32'h00);
        checkOutput("s4_to_pulse", 32'(Buzzer_TimeOver), 32'd1);
        checkOutput("s4_led_clr", 32'(LED_Out), 32'd0);
        checkOutput("s4_foul_clr", 32'(Foul_Out), 32'd0);
      end
      if (i == 31) checkOutput("s4_to_single", 32'(Buzzer_TimeOver), 32'd0);
    end
    checkOutput("s4_scores_kept", 32'(Score_Bus), 32'h0100);

    $display("[TB] scenario: score saturation and abort");
    for (int r = 1; r <= 10; r++) begin
      grantPlayer(4'b0001);
      applyStimulus(1, 4'b0001, 1, 0);
      if (r == 9)  checkOutput("s5_score_9", 32'(Score_Bus[3:0]), 32'd9);
      if (r == 10) checkOutput("s5_score_sat", 32'(Score_Bus[3:0]), 32'd9);
    end
    grantPlayer(4'b0001);
    repeat (25) applyStimulus(1, 4'b0001, 0, 0);
    checkOutput("s5_timer_late", 32'({TimerH, TimerL}), 32'h01);
    applyStimulus(0, 4'b0001, 0, 0);
    checkOutput("s5_abort_led", 32'(LED_Out), 32'd0);
    checkOutput("s5_abort_timer", 32'({TimerH, TimerL}), 32'h00);
    checkOutput("s5_abort_to", 32'(Buzzer_TimeOver), 32'd0);
    checkOutput("s5_abort_scores", 32'(Score_Bus), 32'h0109);
    repeat (8) applyStimulus(0, 4'b0000, 0, 0);

    $display("[TB] scenario: asynchronous reset mid-answer");
    grantPlayer(4'b0010);
    repeat (3) applyStimulus(1, 4'b0010, 0, 0);
    #3 RSTn = 0;
    #1;
    checkOutput("s6_rst_led", 32'(LED_Out), 32'd0);
    checkOutput("s6_rst_player", 32'(Player_Number), 32'd0);
    checkOutput("s6_rst_timer", 32'({TimerH, TimerL}), 32'd0);
    checkOutput("s6_rst_score", 32'(Score_Bus), 32'd0);
    Start = 0; Key_In = 0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1;
    applyStimulus(0, 4'b0000, 0, 0);

    $display("[TB] scenario: stray verdicts and simultaneous OK/NG");
    applyStimulus(1, 4'b0000, 1, 0);
    applyStimulus(1, 4'b0000, 0, 1);
    checkOutput("s7_stray_judge", 32'(Score_Bus), 32'd0);
    grantPlayer(4'b1000);
    applyStimulus(1, 4'b1000, 1, 1);
    checkOutput("s7_ok_wins", 32'(Score_Bus[15:12]), 32'd1);
    repeat (4) applyStimulus(0, 4'b0000, 0, 0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/quiz_round_ctrl.md
# quiz_round_ctrl

Round sequencer and first-press arbiter for the 4-player quiz responder. It arms a round on the host Start switch and grants the first valid player key with fixed priority. It disqualifies players who pressed before arming, runs the BCD answer countdown, applies the host's correct/wrong verdict to per-player scores, and drives the buzzer, LED and digitron-facing signals.

## Interface
Parameters:
- TICK_DIV, 50_000_000: CLK cycles per countdown second.
- ANSWER_SEC, 20: answer window in seconds; range 1..99.
- SCORE_MAX, 9: saturating score ceiling; range 1..9.

Ports:
- CLK  in  1  system clock; the block's only clock.
- RSTn  in  1  asynchronous, active-low reset.
- Start  in  1  host round switch, level; rising edge arms a round, low aborts it.
- Key_In  in  4  player keys, active-high; bit 0 = player 1. Synchronous and debounced upstream.
- Judge_OK  in  1  one-cycle pulse: the granted answer is correct.
- Judge_NG  in  1  one-cycle pulse: the granted answer is wrong.
- LED_Out  out  4  one-hot granted player; 0 when no player holds the grant.
- Player_Number  out  4  granted player as 1..4; 0 when none.
- TimerH, TimerL  out  4 each  remaining seconds, BCD tens and units.
- Score_Bus  out  16  four 4-bit scores; [3:0] = player 1.
- Foul_Out  out  4  players disqualified for the current or pending round.
- Buzzer_Answer  out  1  one-cycle pulse on grant.
- Buzzer_TimeOver  out  1  one-cycle pulse on countdown expiry.

## Operation
- States:
  - IDLE: no round active.
  - ARMED: waiting for a valid key.
  - ANSWER: grant held, countdown running.
- Key events are rising edges, detected against a registered copy of Key_In.
- IDLE:
  - A key edge sets the matching Foul_Out bit.
  - A Start rising edge moves to ARMED.
  - Foul_Out is held on entry to ARMED.
- ARMED:
  - Valid edges = key edges AND NOT Foul_Out.
  - If any valid edge occurs, grant the lowest index and move to ANSWER.
  - Load TimerH:TimerL = ANSWER_SEC in BCD, clear the tick divider, and pulse Buzzer_Answer.
  - Key edges on fouled players are ignored.
- ANSWER:
  - Countdown decrements once per TICK_DIV cycles. When TimerL = 0: TimerL becomes 9 and TimerH decrements.
  - Judge_OK: granted score +1, saturating at SCORE_MAX; go to IDLE.
  - Judge_NG: granted score −1, saturating at 0; go to IDLE.
  - If Judge_OK and Judge_NG arrive in the same cycle, Judge_OK wins.
  - Countdown reaching 00: pulse Buzzer_TimeOver, no score change, go to IDLE.
  - If a judge pulse and expiry occur in the same cycle, the judge pulse wins and there is no TimeOver pulse.
  - Key edges are ignored.
- Start low in ARMED or ANSWER aborts the round: go to IDLE with no score change and no buzzer pulse.
- On every transition into IDLE:
  - Clear LED_Out, Player_Number, Foul_Out and the timer.
  - Scores are kept.
- Judge pulses outside ANSWER are ignored.
- Scores clear only on reset.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs = 0, including all scores and the timer.
  - Registered key copy = 0.
- All outputs are registered.
- Key edge detected at clock edge n (Key_In high at n, low at n−1) → LED_Out, Player_Number, the timer load and Buzzer_Answer are visible after edge n+1.
- Simultaneous valid edges in one cycle: the lowest index wins; the others are discarded, not queued.
- Expiry timing: the first decrement occurs TICK_DIV cycles after the grant. 00 is reached ANSWER_SEC×TICK_DIV cycles after the grant. Buzzer_TimeOver is asserted in the same cycle that the timer shows 00 and the state returns to IDLE.
- A judge pulse sampled at edge n → the score update and IDLE are visible after edge n.
- A Start rise and a key edge in the same cycle while in IDLE: the key sets its foul bit and the round arms with that player fouled.
- Asserting RSTn mid-round returns everything to reset values immediately.

## Structure
- Package quiz_pkg:
  - state enum (IDLE, ARMED, ANSWER)
  - N_PLAYERS = 4
  - SCORE_W = 4
  - BCD digit width
  - function for the ANSWER_SEC → BCD conversion
- Sub-module bcd_countdown:
  - Contains the tick divider plus the 2-digit BCD down-counter.
  - Inputs: load, run.
  - Outputs: TimerH, TimerL, expire pulse.
- Arbitration, fouls, scores and the FSM stay in the top module.

## Test plan
All scenarios use TICK_DIV=10 and ANSWER_SEC=3.
- Start rise, then Key_In=0100 → after 1 cycle LED_Out=0100, Player_Number=3, Buzzer_Answer=1 for 1 cycle, timer=03; then Judge_OK → score3=1, state IDLE, LED_Out=0.
- Armed, Key_In=0110 in one cycle → player 2 granted; later Key_In[0] edge ignored; Judge_NG with score2=0 → score2 stays 0.
- Key_In[0] pressed in IDLE, then Start rise, Key_In[0] edge, then Key_In[3] edge → Foul_Out=0001, player 4 granted.
- Grant, no judge → timer 03→02→01→00 at 10-cycle steps; Buzzer_TimeOver pulses at 30 cycles after grant; scores unchanged.
- Saturation: award player 1 Judge_OK ten times → score1=9. Grant with 5 cycles left of ANSWER, drop Start → IDLE, no pulses, scores kept.
- RSTn low during ANSWER → all outputs 0 immediately; an asynchronous reset assertion between edges is checked.
